// File: rtl/accum_ctrl.sv
// accum_ctrl: sequences accumulate / drain commands over a wrapping row range of the accumulator table.
// Latency: a column write trails its inValid by one cycle; drain data follows its read issue by one cycle.
// Backpressure: drain stalls while outReady=0, holding rdAddr on the pending row so rdData stays stable.
// Optional feature: define ACCUM_CLEAR_ON_DRAIN_EN to write zero back to each row as it is drained.
module accum_ctrl #(
  parameter int MAX_OUT_ROWS = 1024,
  localparam int ADDR_W = $clog2(MAX_OUT_ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cmdDrain,
  input  logic              cmdAccum,
  input  logic [ADDR_W-1:0] cmdBase,
  input  logic [ADDR_W:0]   cmdRows,
  input  logic              inValid,
  output logic [ADDR_W-1:0] rdAddr,
  output logic [ADDR_W-1:0] wrAddr,
  output logic              wrEn,
  output logic              addSel,
  output logic              wrZero,
  output logic              outValid,
  input  logic              outReady,
  output logic [ADDR_W-1:0] outAddr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0]   MAX_ROWS = (ADDR_W + 1)'(MAX_OUT_ROWS);
  localparam logic [ADDR_W+1:0] MAX_SUM  = (ADDR_W + 2)'(MAX_OUT_ROWS);

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   rows_q;
  logic              accum_q;
  logic [ADDR_W:0]   cnt;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              add_sel_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              done_q;

  logic [ADDR_W:0]   rows_clamped;
  logic [ADDR_W+1:0] addr_sum;
  logic [ADDR_W-1:0] cur_addr;
  logic              stall;
  logic              issue;

  // Oversized commands cover the whole table exactly once, so rows never alias within a command.
  assign rows_clamped = (cmdRows > MAX_ROWS) ? MAX_ROWS : cmdRows;

  // base+cnt reduced modulo the table depth; one subtraction suffices since both terms are < depth+1.
  assign addr_sum = {2'b00, base_q} + {1'b0, cnt};
  assign cur_addr = (addr_sum >= MAX_SUM) ? ADDR_W'(addr_sum - MAX_SUM) : addr_sum[ADDR_W-1:0];

  // A stalled drain beat keeps re-reading its own row so the registered read output does not move.
  assign stall  = (state == S_DRAIN) && out_valid_q && !outReady;
  assign issue  = (state == S_DRAIN) && (cnt < rows_q) && (!out_valid_q || outReady);
  assign rdAddr = stall ? out_addr_q : cur_addr;

  // Command FSM; write controls are registered one cycle behind the read they pair with.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      base_q      <= '0;
      rows_q      <= '0;
      accum_q     <= 1'b0;
      cnt         <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      add_sel_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      add_sel_q <= 1'b0;
      done_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q  <= cmdBase;
            rows_q  <= rows_clamped;
            accum_q <= cmdAccum;
            cnt     <= '0;
            if (rows_clamped == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else if (cmdDrain) begin
              state <= S_DRAIN;
            end else begin
              state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (inValid) begin
            cnt       <= cnt + 1'b1;
            wr_en_q   <= 1'b1;
            wr_addr_q <= cur_addr;
            add_sel_q <= accum_q;
            if ((cnt + 1'b1) == rows_q) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          state  <= S_DONE;
          done_q <= 1'b1;
        end
        S_DRAIN: begin
          if (issue) begin
            out_valid_q <= 1'b1;
            out_addr_q  <= cur_addr;
            cnt         <= cnt + 1'b1;
          end else if (outReady) begin
            out_valid_q <= 1'b0;
          end
          if ((cnt == rows_q) && out_valid_q && outReady) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign outValid = out_valid_q;
  assign outAddr  = out_addr_q;
  assign busy     = (state != S_IDLE);
  assign done     = done_q;

`ifdef ACCUM_CLEAR_ON_DRAIN_EN
  logic clr_wr;

  // Each accepted drain beat zeroes its row in the same cycle; accumulate writes never overlap a drain.
  assign clr_wr = (state == S_DRAIN) && out_valid_q && outReady;
  assign wrEn   = wr_en_q | clr_wr;
  assign wrAddr = clr_wr ? out_addr_q : wr_addr_q;
  assign wrZero = clr_wr;
  assign addSel = add_sel_q & ~clr_wr;
`else
  assign wrEn   = wr_en_q;
  assign wrAddr = wr_addr_q;
  assign wrZero = 1'b0;
  assign addSel = add_sel_q;
`endif

endmodule

// File: tb/tb_accum_ctrl.sv
// Scoreboard bench for accum_ctrl: directed commands push expected writes, drain beats and done pulses;
// a negedge monitor pops and compares them whenever the DUT presents the matching output.
// A small single-column model checks the stored values the write controls produce.
module tb_accum_ctrl;
  localparam int MAX = 1024;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          reset, start, cmdDrain, cmdAccum, inValid, outReady;
  logic [AW-1:0] cmdBase;
  logic [AW:0]   cmdRows;
  logic [AW-1:0] rdAddr, wrAddr, outAddr;
  logic          wrEn, addSel, wrZero, outValid, busy, done;

  accum_ctrl #(.MAX_OUT_ROWS(MAX)) dut (
    .clk(clk), .reset(reset), .start(start), .cmdDrain(cmdDrain), .cmdAccum(cmdAccum),
    .cmdBase(cmdBase), .cmdRows(cmdRows), .inValid(inValid), .rdAddr(rdAddr), .wrAddr(wrAddr),
    .wrEn(wrEn), .addSel(addSel), .wrZero(wrZero), .outValid(outValid), .outReady(outReady),
    .outAddr(outAddr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One accumulator column: registered read, write data = (addSel ? rdData : 0) + upstream, or zero.
  int mem [MAX];
  int rd_data = 0;
  int dat = 0;
  int dat_d = 0;
  bit preload = 1'b1;
  always @(posedge clk) begin
    rd_data <= mem[rdAddr];
    dat_d   <= dat;
    if (preload) begin
      for (int i = 0; i < MAX; i++) mem[i] <= i;
    end else if (wrEn) begin
      mem[wrAddr] <= wrZero ? 0 : ((addSel ? rd_data : 0) + dat_d);
    end
  end

  typedef struct { int addr; int sel; int zero; int cyc; } wr_t;
  typedef struct { int addr; int cyc; } beat_t;
  wr_t   wq[$];
  beat_t dq[$];
  int    doneq[$];

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_wr(input int a, input int s, input int z, input int c);
    wq.push_back('{addr: a, sel: s, zero: z, cyc: c});
  endtask

  task automatic exp_beat(input int a, input int c);
    dq.push_back('{addr: a, cyc: c});
`ifdef ACCUM_CLEAR_ON_DRAIN_EN
    exp_wr(a, 0, 1, c);
`endif
  endtask

  // Monitor: pops expectations whenever the DUT shows a write, a drain handshake or done.
  wr_t   mw;
  beat_t mb;
  int    md;
  always @(negedge clk) begin
    if (mon_en) begin
      if (wrEn) begin
        if (wq.size() == 0) chk("unexpected write addr", int'(wrAddr), -1);
        else begin
          mw = wq.pop_front();
          chk("write addr", int'(wrAddr), mw.addr);
          chk("write addSel", int'(addSel), mw.sel);
          chk("write wrZero", int'(wrZero), mw.zero);
          chk("write cycle", cyc, mw.cyc);
        end
      end
      if (outValid && outReady) begin
        if (dq.size() == 0) chk("unexpected beat addr", int'(outAddr), -1);
        else begin
          mb = dq.pop_front();
          chk("beat outAddr", int'(outAddr), mb.addr);
          chk("beat cycle", cyc, mb.cyc);
        end
      end
      if (outValid && !outReady) chk("stall rdAddr", int'(rdAddr), int'(outAddr));
      if (done) begin
        if (doneq.size() == 0) chk("unexpected done cycle", cyc, -1);
        else begin
          md = doneq.pop_front();
          chk("done cycle", cyc, md);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit drn, input bit acc, input int base, input int rows, output int t);
    t        = cyc;
    start    = 1'b1;
    cmdDrain = drn;
    cmdAccum = acc;
    cmdBase  = AW'(base);
    cmdRows  = (AW + 1)'(rows);
    step();
    start    = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 3000) begin
      step();
      k++;
    end
    if (busy) chk({name, " idle timeout busy"}, int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit pat_v [6];
    bit pat_r [6];

    // Reset held for two edges with start asserted.
    reset = 1'b0; start = 1'b1; cmdDrain = 1'b0; cmdAccum = 1'b1; cmdBase = 10'd7;
    cmdRows = 11'd4; inValid = 1'b1; outReady = 1'b0;
    step(); step();
    chk("reset wrEn", int'(wrEn), 0);
    chk("reset addSel", int'(addSel), 0);
    chk("reset wrZero", int'(wrZero), 0);
    chk("reset outValid", int'(outValid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset wrAddr", int'(wrAddr), 0);
    chk("reset outAddr", int'(outAddr), 0);
    chk("reset rdAddr", int'(rdAddr), 0);
    preload = 1'b0;
    reset = 1'b1; start = 1'b0; inValid = 1'b0;
    step();
    chk("idle after reset busy", int'(busy), 0);
    mon_en = 1'b1;

    // Accumulate-add 8 rows wrapping from 1020.
    issue(1'b0, 1'b1, 1020, 8, t);
    for (int i = 0; i < 8; i++) exp_wr((1020 + i) % MAX, 1, 0, t + 2 + i);
    doneq.push_back(t + 10);
    chk("busy after start", int'(busy), 1);
    inValid = 1'b1; dat = 3;
    repeat (8) step();
    inValid = 1'b0;
    wait_idle("accum");

    // Overwrite 4 rows with gaps in inValid.
    pat_v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    issue(1'b0, 1'b0, 100, 4, t);
    exp_wr(100, 0, 0, t + 2);
    exp_wr(101, 0, 0, t + 4);
    exp_wr(102, 0, 0, t + 5);
    exp_wr(103, 0, 0, t + 7);
    doneq.push_back(t + 8);
    for (int i = 0; i < 6; i++) begin
      inValid = pat_v[i];
      dat = 10 + i;
      step();
    end
    inValid = 1'b0;
    wait_idle("overwrite");
    chk("mem[100]", mem[100], 10);
    chk("mem[101]", mem[101], 12);
    chk("mem[102]", mem[102], 13);
    chk("mem[103]", mem[103], 15);

    // Drain 3 rows from 5 under backpressure.
    pat_r = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    issue(1'b1, 1'b0, 5, 3, t);
    exp_beat(5, t + 3);
    exp_beat(6, t + 4);
    exp_beat(7, t + 6);
    doneq.push_back(t + 7);
    for (int i = 0; i < 6; i++) begin
      outReady = pat_r[i];
      step();
    end
    outReady = 1'b1;
    wait_idle("drain");

    // Zero rows, issued on the first idle cycle after the previous done.
    issue(1'b0, 1'b1, 50, 0, t);
    doneq.push_back(t + 1);
    chk("zero rows busy", int'(busy), 1);
    wait_idle("zero rows");

    // Drain rows 200..201, then accumulate-add 7 into the same rows.
    issue(1'b1, 1'b0, 200, 2, t);
    exp_beat(200, t + 2);
    exp_beat(201, t + 3);
    doneq.push_back(t + 4);
    wait_idle("drain 200");
    issue(1'b0, 1'b1, 200, 2, t);
    exp_wr(200, 1, 0, t + 2);
    exp_wr(201, 1, 0, t + 3);
    doneq.push_back(t + 4);
    inValid = 1'b1; dat = 7;
    step(); step();
    inValid = 1'b0; dat = 0;
    wait_idle("accum 200");
`ifdef ACCUM_CLEAR_ON_DRAIN_EN
    chk("mem[200] after clear+add", mem[200], 7);
    chk("mem[201] after clear+add", mem[201], 7);
`else
    chk("mem[200] after add", mem[200], 207);
    chk("mem[201] after add", mem[201], 208);
`endif

    // Oversized row count clamps to the full table.
    issue(1'b1, 1'b0, 0, 1100, t);
    for (int i = 0; i < MAX; i++) exp_beat(i, t + 2 + i);
    doneq.push_back(t + MAX + 2);
    wait_idle("clamp drain");

    step(); step();
    chk("writes never seen", wq.size(), 0);
    chk("beats never seen", dq.size(), 0);
    chk("done pulses never seen", doneq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
